cla_accumulator: RTL and testbench

- Multi-cycle signed accumulator that sequences a stream of 16-bit operands through one instance of the existing 16-bit CLA (ports A, B, sub, Sum, Ovfl).
- Sits directly upstream and downstream of the CLA: it drives the CLA's A/B/sub inputs from its accumulator and the operand stream, and registers Sum/Ovfl back into the accumulator and sticky flag.
- Supports multi-operand reductions and accumulate-style ALU operations in the pipeline.

---
 rtl/cla_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_cla_accumulator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_accumulator.sv
// Multi-cycle signed accumulator sequencing an operand stream through one 16-bit CLA.
// Optional saturation on overflow when CLA_ACC_SATURATE_EN is defined; wrap-around otherwise.

module cla_16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        sub,
    output logic [15:0] Sum,
    output logic        Ovfl
);

    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cg;
    logic [16:0] c;

    always_comb begin
        b_eff = B ^ {16{sub}};
        g     = A & b_eff;
        p     = A ^ b_eff;
        gg    = '0;
        gp    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | ((&p[4*k+1 +: 3]) & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end

        // Second-level lookahead across the four 4-bit groups; sub is the carry-in.
        cg[0] = sub;
        cg[1] = gg[0] | (gp[0] & cg[0]);
        cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg[0]);
        cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cg[0]);
        cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & cg[0]);

        c = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | ((&p[4*k +: 3]) & cg[k]);
        end
        c[16] = cg[4];

        Sum  = p ^ c[15:0];
        Ovfl = c[16] ^ c[15];
    end

endmodule

module cla_accumulator #(
    parameter int unsigned MAX_OPS = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             op_valid,
    input  logic [15:0]      op_data,
    input  logic             op_sub,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             ovfl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_OPS_C = CNT_W'(MAX_OPS);

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      acc_q;
    logic [15:0]      acc_next;
    logic             ovfl_q;
    logic             done_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] ops_clamped;
    logic             start_ok;
    logic             accept;
    logic             last_accept;
    logic             enter_done;
    logic [15:0]      cla_sum;
    logic             cla_ovfl;

    cla_16 u_cla (
        .A    (acc_q),
        .B    (op_data),
        .sub  (op_sub),
        .Sum  (cla_sum),
        .Ovfl (cla_ovfl)
    );

    always_comb begin
        op_ready    = (state_q == ACCUM);
        busy        = (state_q == ACCUM);
        start_ok    = start && (state_q == IDLE || state_q == DONE);
        accept      = op_valid && op_ready;
        last_accept = accept && (remaining_q == CNT_W'(1));
        ops_clamped = (num_ops > MAX_OPS_C) ? MAX_OPS_C : num_ops;
        // A zero-operand start re-enters DONE, so it must pulse done again even from DONE.
        enter_done  = last_accept || (start_ok && (num_ops == '0));
    end

    always_comb begin
`ifdef CLA_ACC_SATURATE_EN
        if (cla_ovfl) begin
            acc_next = acc_q[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            acc_next = cla_sum;
        end
`else
        acc_next = cla_sum;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (num_ops == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_accept) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ovfl_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            done_q <= enter_done;
            if (start_ok) begin
                acc_q       <= '0;
                ovfl_q      <= 1'b0;
                remaining_q <= ops_clamped;
            end else if (accept) begin
                acc_q       <= acc_next;
                ovfl_q      <= ovfl_q | cla_ovfl;
                remaining_q <= remaining_q - CNT_W'(1);
            end
        end
    end

    assign done   = done_q;
    assign result = acc_q;
    assign ovfl   = ovfl_q;

endmodule

// File: tb/tb_cla_accumulator.sv
// Scoreboard bench for cla_accumulator: stimulus pushes expected results, a negedge
// monitor pops and compares on every done pulse; inline checks cover handshake timing.

module tb_cla_accumulator;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             op_valid;
    logic [15:0]      op_data;
    logic             op_sub;
    logic             op_ready;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic             ovfl;

    typedef struct packed {
        logic [15:0] res;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    cla_accumulator #(.MAX_OPS(8), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_ops  (num_ops),
        .op_valid (op_valid),
        .op_data  (op_data),
        .op_sub   (op_sub),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovfl     (ovfl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got done=1, expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (result !== e.res || ovfl !== e.ov) begin
                    miscompares++;
                    $display("FAIL done_result: got 0x%04h ovfl=%0b, expected 0x%04h ovfl=%0b at %0t",
                             result, ovfl, e.res, e.ov, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic [15:0] res, input logic ov);
        exp_t e;
        e.res = res;
        e.ov  = ov;
        exp_q.push_back(e);
        start   = 1'b1;
        num_ops = n;
        tick();
        start = 1'b0;
    endtask

    // Presents one operand and waits (bounded) until it is accepted; leaves op_valid high.
    task automatic send_op(input logic [15:0] d, input logic s);
        bit accepted = 0;
        op_valid = 1'b1;
        op_data  = d;
        op_sub   = s;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (op_ready) accepted = 1;
            tick();
        end
        if (!accepted) check("accept_timeout", 16'h0, 16'h1);
    endtask

    initial begin
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        rst_n    = 1'b0;
        start    = 1'b0;
        num_ops  = '0;
        op_valid = 1'b0;
        op_data  = '0;
        op_sub   = 1'b0;
        tick();
        tick();
        check("reset_result", result, 16'h0000);
        check("reset_flags", {12'h0, ovfl, done, busy, op_ready}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // 5 + 3 - 2 back-to-back
        do_start(4'd3, 16'h0006, 1'b0);
        check("t1_busy", {15'h0, busy}, 16'h1);
        send_op(16'h0005, 1'b0);
        send_op(16'h0003, 1'b0);
        send_op(16'h0002, 1'b1);
        op_valid = 1'b0;
        check("t1_done_pulse", {15'h0, done}, 16'h1);
        check("t1_busy_after", {15'h0, busy}, 16'h0);
        tick();
        check("t1_done_single", {15'h0, done}, 16'h0);
        tick();
        check("t1_hold", result, 16'h0006);

        // 0x7FFF + 1 overflows
`ifdef CLA_ACC_SATURATE_EN
        exp_a = 16'h7FFF;
`else
        exp_a = 16'h8000;
`endif
        do_start(4'd2, exp_a, 1'b1);
        send_op(16'h7FFF, 1'b0);
        send_op(16'h0001, 1'b0);
        op_valid = 1'b0;
        check("t2_done", {15'h0, done}, 16'h1);
        tick();

        // 0 - 0x8000 overflows
        do_start(4'd1, exp_a, 1'b1);
        send_op(16'h8000, 1'b1);
        op_valid = 1'b0;
        check("t3_ovfl", {15'h0, ovfl}, 16'h1);
        tick();

        // stalls between operands, start mid-stall ignored
        do_start(4'd2, 16'h1235, 1'b0);
        send_op(16'h1234, 1'b0);
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start   = (i == 1);
            num_ops = 4'd1;
            check("t4_stall_busy", {15'h0, busy}, 16'h1);
            tick();
        end
        start = 1'b0;
        check("t4_partial", result, 16'h1234);
        send_op(16'h0001, 1'b0);
        op_valid = 1'b0;
        check("t4_done", {15'h0, done}, 16'h1);
        tick();

        // zero operands, then a start honoured in the done-entry cycle
        do_start(4'd0, 16'h0000, 1'b0);
        check("t5_done_now", {15'h0, done}, 16'h1);
        check("t5_no_ready", {15'h0, op_ready}, 16'h0);
        do_start(4'd1, 16'h0009, 1'b0);
        check("t5_restart_busy", {15'h0, busy}, 16'h1);
        send_op(16'h0009, 1'b0);
        op_valid = 1'b0;
        tick();

        // 15 requested, clamped to 8 accepts
        do_start(4'd15, 16'h0008, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t6_busy_before_last", {15'h0, busy}, 16'h1);
            send_op(16'h0001, 1'b0);
        end
        check("t6_done_after_8", {15'h0, done}, 16'h1);
        check("t6_no_ready", {15'h0, op_ready}, 16'h0);
        tick();
        op_valid = 1'b0;
        check("t6_hold", result, 16'h0008);

        // reset mid-accumulation discards everything
        exp_b = 16'h0000;
        do_start(4'd4, 16'h0000, 1'b0);
        void'(exp_q.pop_back());
        send_op(16'h0010, 1'b0);
        op_valid = 1'b0;
        check("t7_partial", result, 16'h0010);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t7_result", result, exp_b);
        check("t7_flags", {12'h0, ovfl, done, busy, op_ready}, 16'h0000);
        tick();
        tick();
        check("t7_no_done", {15'h0, done}, 16'h0);

        check("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
